// File: rtl/fir_serial_mc.sv
// Multi-channel FIR filter with bit-serial sample input and output.
// Every channel has its own delay line; one MAC walks the taps one per cycle.
module fir_serial_mc #(
   parameter int DATA_WIDTH   = 24,
   parameter int FIR_DEPTH    = 32,
   parameter int NUM_CHANNELS = 2,
   parameter int COEF_WIDTH   = 18,
   parameter int COEF_FRAC    = 16,
   parameter int LSB_FIRST    = 1
) (
   input  logic                                                      i_clk,
   input  logic                                                      i_rst_n,
   input  logic                                                      i_en,
   input  logic                                                      i_din,
   input  logic                                                      i_din_valid,
   output logic                                                      o_ready,
   input  logic                                                      i_coef_we,
   input  logic [$clog2(FIR_DEPTH)-1:0]                              i_coef_addr,
   input  logic signed [COEF_WIDTH-1:0]                              i_coef_data,
   output logic                                                      o_dout,
   output logic                                                      o_dout_valid,
   output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] o_dout_chan,
   input  logic                                                      i_ready
);

   localparam int CAW  = $clog2(FIR_DEPTH);
   localparam int CHW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int BCW  = $clog2(DATA_WIDTH);
   localparam int TCW  = $clog2(FIR_DEPTH + 1);
   localparam int PW   = DATA_WIDTH + COEF_WIDTH;
   localparam int ACCW = PW + $clog2(FIR_DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MAC  = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   localparam logic [COEF_WIDTH-1:0] COEF_ONE = {{(COEF_WIDTH-1){1'b0}}, 1'b1} << COEF_FRAC;

   logic [1:0]             state_q, state_d;
   logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]  sr_in_q, sr_in_d;
   logic [TCW-1:0]         tap_cnt_q, tap_cnt_d;
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic [DATA_WIDTH-1:0]  out_sr_q, out_sr_d;
   logic [BCW-1:0]         out_cnt_q, out_cnt_d;
   logic [CHW-1:0]         chan_q, chan_d;
   logic [CHW-1:0]         dchan_q, dchan_d;
   logic                   push;

   logic signed [DATA_WIDTH-1:0] x_q [NUM_CHANNELS][FIR_DEPTH];
   logic signed [COEF_WIDTH-1:0] coef_q [FIR_DEPTH];

   logic                         coef_we_ok;
   logic [FIR_DEPTH-1:0]         coef_hit;
   logic [DATA_WIDTH-1:0]        sr_in_shift;
   logic [DATA_WIDTH-1:0]        out_sr_shift;
   logic [CAW-1:0]               tap_idx;
   logic signed [DATA_WIDTH-1:0] mac_x;
   logic signed [COEF_WIDTH-1:0] mac_coef;
   logic signed [PW-1:0]         prod;
   logic signed [ACCW-1:0]       prod_ext;
   logic signed [ACCW-1:0]       acc_shr;
   logic                         pos_ovf, neg_ovf;
   logic [DATA_WIDTH-1:0]        sat_val;

   // Coefficients may only change between frames so a MAC pass never mixes old and new taps.
   assign coef_we_ok = i_coef_we && (state_q == S_IDLE) && (bit_cnt_q == '0);

   genvar gi;
   generate
      for (gi = 0; gi < FIR_DEPTH; gi++) begin : g_coef_dec
         assign coef_hit[gi] = coef_we_ok && (i_coef_addr == CAW'(gi));
      end
   endgenerate

   always_comb begin
      if (LSB_FIRST != 0) begin
         sr_in_shift  = {i_din, sr_in_q[DATA_WIDTH-1:1]};
         out_sr_shift = {1'b0, out_sr_q[DATA_WIDTH-1:1]};
      end else begin
         sr_in_shift  = {sr_in_q[DATA_WIDTH-2:0], i_din};
         out_sr_shift = {out_sr_q[DATA_WIDTH-2:0], 1'b0};
      end
   end

   assign tap_idx  = tap_cnt_q[CAW-1:0];
   assign mac_x    = x_q[chan_q][tap_idx];
   assign mac_coef = coef_q[tap_idx];
   assign prod     = mac_coef * mac_x;
   assign prod_ext = {{(ACCW-PW){prod[PW-1]}}, prod};

   // Arithmetic shift floors toward -inf; overflow means the bits above the
   // result sign are not all copies of it.
   assign acc_shr = acc_q >>> COEF_FRAC;
   assign pos_ovf = ~acc_shr[ACCW-1] & (|acc_shr[ACCW-2:DATA_WIDTH-1]);
   assign neg_ovf = acc_shr[ACCW-1] & ~(&acc_shr[ACCW-2:DATA_WIDTH-1]);

   always_comb begin
      if (pos_ovf) begin
         sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else if (neg_ovf) begin
         sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         sat_val = acc_shr[DATA_WIDTH-1:0];
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      sr_in_d   = sr_in_q;
      tap_cnt_d = tap_cnt_q;
      acc_d     = acc_q;
      out_sr_d  = out_sr_q;
      out_cnt_d = out_cnt_q;
      chan_d    = chan_q;
      dchan_d   = dchan_q;
      push      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_din_valid) begin
               sr_in_d = sr_in_shift;
               if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                  bit_cnt_d = '0;
                  push      = 1'b1;
                  acc_d     = '0;
                  tap_cnt_d = '0;
                  state_d   = S_MAC;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         S_MAC: begin
            // The count runs one past the last tap; that extra edge loads the result.
            if (tap_cnt_q == TCW'(FIR_DEPTH)) begin
               out_sr_d  = sat_val;
               out_cnt_d = '0;
               dchan_d   = chan_q;
               state_d   = S_OUT;
            end else begin
               acc_d     = acc_q + prod_ext;
               tap_cnt_d = tap_cnt_q + 1'b1;
            end
         end
         S_OUT: begin
            if (i_ready) begin
               out_sr_d = out_sr_shift;
               if (out_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                  out_cnt_d = '0;
                  state_d   = S_IDLE;
                  chan_d    = (chan_q == CHW'(NUM_CHANNELS - 1)) ? '0 : chan_q + 1'b1;
               end else begin
                  out_cnt_d = out_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         sr_in_q   <= '0;
         tap_cnt_q <= '0;
         acc_q     <= '0;
         out_sr_q  <= '0;
         out_cnt_q <= '0;
         chan_q    <= '0;
         dchan_q   <= '0;
      end else if (i_en) begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         sr_in_q   <= sr_in_d;
         tap_cnt_q <= tap_cnt_d;
         acc_q     <= acc_d;
         out_sr_q  <= out_sr_d;
         out_cnt_q <= out_cnt_d;
         chan_q    <= chan_d;
         dchan_q   <= dchan_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            for (int k = 0; k < FIR_DEPTH; k++) begin
               x_q[c][k] <= '0;
            end
         end
      end else if (i_en && push) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (chan_q == CHW'(c)) begin
               x_q[c][0] <= sr_in_shift;
               for (int k = 1; k < FIR_DEPTH; k++) begin
                  x_q[c][k] <= x_q[c][k-1];
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < FIR_DEPTH; k++) begin
            if (k == 0) begin
               coef_q[k] <= COEF_ONE;
            end else begin
               coef_q[k] <= '0;
            end
         end
      end else if (i_en) begin
         for (int k = 0; k < FIR_DEPTH; k++) begin
            if (coef_hit[k]) begin
               coef_q[k] <= i_coef_data;
            end
         end
      end
   end

   assign o_ready      = (state_q == S_IDLE);
   assign o_dout_valid = (state_q == S_OUT);
   assign o_dout       = (LSB_FIRST != 0) ? out_sr_q[0] : out_sr_q[DATA_WIDTH-1];
   assign o_dout_chan  = dchan_q;

endmodule

// File: tb/tb_fir_serial_mc.sv
// Directed bench for fir_serial_mc: LSB-first instance A, MSB-first instance B,
// shared clock, reset, enable and coefficient bus.
`timescale 1ns/1ps
module tb_fir_serial_mc;
   localparam int DW = 24;
   localparam int NT = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b1;
   logic [1:0]        din, din_valid, ready_in;
   logic [1:0]        rdy_out, dout, dout_valid, dout_chan;
   logic              coef_we;
   logic [4:0]        coef_addr;
   logic signed [17:0] coef_data;
   int                checks = 0;
   int                failures = 0;
   int                lat;
   logic [23:0]       part_exp;

   always #5 clk = ~clk;

   fir_serial_mc #(.LSB_FIRST(1)) u_dut_lsb (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
      .i_din(din[0]), .i_din_valid(din_valid[0]), .o_ready(rdy_out[0]),
      .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_data(coef_data),
      .o_dout(dout[0]), .o_dout_valid(dout_valid[0]), .o_dout_chan(dout_chan[0]),
      .i_ready(ready_in[0])
   );

   fir_serial_mc #(.LSB_FIRST(0)) u_dut_msb (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
      .i_din(din[1]), .i_din_valid(din_valid[1]), .o_ready(rdy_out[1]),
      .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_data(coef_data),
      .o_dout(dout[1]), .o_dout_valid(dout_valid[1]), .o_dout_chan(dout_chan[1]),
      .i_ready(ready_in[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wr_coef(input logic [4:0] addr, input logic signed [17:0] data);
      coef_we   = 1'b1;
      coef_addr = addr;
      coef_data = data;
      @(negedge clk);
      coef_we   = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Instance 1 is MSB-first. A stall either drops i_en (with junk on the
   // serial line and valid held high) or opens a valid gap.
   task automatic send_word(input int s, input logic [23:0] val, input int stall_after,
                            input int stall_len, input bit stall_en);
      for (int i = 0; i < DW; i++) begin
         din[s]       = (s == 1) ? val[DW-1-i] : val[i];
         din_valid[s] = 1'b1;
         @(negedge clk);
         if (i == stall_after) begin
            for (int j = 0; j < stall_len; j++) begin
               if (stall_en) begin
                  en     = 1'b0;
                  din[s] = ~din[s];
               end else begin
                  din_valid[s] = 1'b0;
               end
               @(negedge clk);
            end
            en = 1'b1;
         end
      end
      din_valid[s] = 1'b0;
      din[s]       = 1'b0;
   endtask

   task automatic recv_word(input int s, input logic [23:0] exp_val, input logic exp_ch,
                            input int bp_cycles, input int stall_after, input int stall_len,
                            input string tag, output int lat_o);
      logic [23:0] got;
      int          n;
      int          idx;
      got = '0;
      n   = 0;
      while (!dout_valid[s] && n < 200) begin
         @(negedge clk);
         n++;
      end
      lat_o = n;
      chk({tag, "_valid"}, 32'(dout_valid[s]), 32'd1);
      chk({tag, "_chan"}, 32'(dout_chan[s]), 32'(exp_ch));
      idx = (s == 1) ? DW - 1 : 0;
      for (int j = 0; j < bp_cycles; j++) begin
         ready_in[s]  = 1'b0;
         din_valid[s] = 1'b1;
         din[s]       = j[0];
         @(negedge clk);
         chk({tag, "_bp_dout"}, 32'(dout[s]), 32'(exp_val[idx]));
         chk({tag, "_bp_chan"}, 32'(dout_chan[s]), 32'(exp_ch));
         chk({tag, "_bp_ready"}, 32'(rdy_out[s]), 32'd0);
      end
      din_valid[s] = 1'b0;
      din[s]       = 1'b0;
      for (int i = 0; i < DW; i++) begin
         idx         = (s == 1) ? DW - 1 - i : i;
         got[idx]    = dout[s];
         ready_in[s] = 1'b1;
         @(negedge clk);
         if (i == stall_after) begin
            idx = (s == 1) ? DW - 2 - i : i + 1;
            en  = 1'b0;
            for (int j = 0; j < stall_len; j++) begin
               @(negedge clk);
               chk({tag, "_en_hold"}, 32'(dout[s]), 32'(exp_val[idx]));
            end
            en = 1'b1;
         end
      end
      ready_in[s] = 1'b0;
      chk({tag, "_word"}, 32'(got), 32'(exp_val));
      chk({tag, "_done_valid"}, 32'(dout_valid[s]), 32'd0);
      chk({tag, "_done_ready"}, 32'(rdy_out[s]), 32'd1);
      $display("TXN %s inst=%0d word=0x%06h latency=%0d", tag, s, got, lat_o);
   endtask

   initial begin
      din       = '0;
      din_valid = '0;
      ready_in  = '0;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(rdy_out[0]), 32'd1);
      chk("rst_valid", 32'(dout_valid[0]), 32'd0);
      chk("rst_dout", 32'(dout[0]), 32'd0);
      chk("rst_chan", 32'(dout_chan[0]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Passthrough after reset, channel rotation and result latency
      send_word(0, 24'h000123, -1, 0, 1'b0);
      recv_word(0, 24'h000123, 1'b0, 0, -1, 0, "t1_ch0", lat);
      chk("t1_latency_ch0", 32'(lat), 32'(NT + 1));
      send_word(0, 24'hFFFF00, -1, 0, 1'b0);
      recv_word(0, 24'hFFFF00, 1'b1, 0, -1, 0, "t1_ch1", lat);
      chk("t1_latency_ch1", 32'(lat), 32'(NT + 1));

      // MSB-first instance with a 5-cycle valid gap after the eighth bit
      send_word(1, 24'hA5C3F0, 7, 5, 1'b0);
      recv_word(1, 24'hA5C3F0, 1'b0, 1, -1, 0, "t5_msb", lat);
      chk("t5_latency", 32'(lat), 32'(NT + 1));

      // Four taps of 0.25: impulse on ch0 gives four quarter outputs
      do_reset();
      for (int k = 0; k < NT; k++) begin
         wr_coef(5'(k), (k < 4) ? 18'sd16384 : 18'sd0);
      end
      for (int r = 0; r < 5; r++) begin
         send_word(0, (r == 0) ? 24'h010000 : 24'h000000, -1, 0, 1'b0);
         recv_word(0, (r < 4) ? 24'h004000 : 24'h000000, 1'b0, 0, -1, 0, "t2_ch0", lat);
         send_word(0, 24'h000000, -1, 0, 1'b0);
         recv_word(0, 24'h000000, 1'b1, 0, -1, 0, "t2_ch1", lat);
      end

      // All taps 1.0: second frame overflows and must clamp
      do_reset();
      for (int k = 0; k < NT; k++) wr_coef(5'(k), 18'sd65536);
      send_word(0, 24'h7FFFFF, -1, 0, 1'b0);
      recv_word(0, 24'h7FFFFF, 1'b0, 0, -1, 0, "t3_pos1", lat);
      send_word(0, 24'h000000, -1, 0, 1'b0);
      recv_word(0, 24'h000000, 1'b1, 0, -1, 0, "t3_ch1a", lat);
      send_word(0, 24'h7FFFFF, -1, 0, 1'b0);
      recv_word(0, 24'h7FFFFF, 1'b0, 0, -1, 0, "t3_pos2", lat);
      do_reset();
      for (int k = 0; k < NT; k++) wr_coef(5'(k), 18'sd65536);
      send_word(0, 24'h800000, -1, 0, 1'b0);
      recv_word(0, 24'h800000, 1'b0, 0, -1, 0, "t3_neg1", lat);
      send_word(0, 24'h000000, -1, 0, 1'b0);
      recv_word(0, 24'h000000, 1'b1, 0, -1, 0, "t3_ch1b", lat);
      send_word(0, 24'h800000, -1, 0, 1'b0);
      recv_word(0, 24'h800000, 1'b0, 0, -1, 0, "t3_neg2", lat);

      // Backpressure plus enable drops mid-frame and mid-output
      do_reset();
      send_word(0, 24'h3C5A69, 11, 3, 1'b1);
      recv_word(0, 24'h3C5A69, 1'b0, 10, 10, 3, "t4_bp", lat);

      // Coefficient write during MAC must be dropped
      send_word(0, 24'h0ABCDE, -1, 0, 1'b0);
      wr_coef(5'd0, 18'sd0);
      recv_word(0, 24'h0ABCDE, 1'b1, 0, -1, 0, "t6_macwr", lat);
      wr_coef(5'd0, 18'sd32768);
      send_word(0, 24'h111111, -1, 0, 1'b0);
      recv_word(0, 24'h088888, 1'b0, 0, -1, 0, "t6_half", lat);

      // Reset in the middle of a ch1 result
      send_word(0, 24'h222222, -1, 0, 1'b0);
      part_exp = 24'h111111;
      for (int n = 0; n < 200 && !dout_valid[0]; n++) @(negedge clk);
      chk("t6_part_chan", 32'(dout_chan[0]), 32'd1);
      for (int i = 0; i < 5; i++) begin
         chk("t6_part_bit", 32'(dout[0]), 32'(part_exp[i]));
         ready_in[0] = 1'b1;
         @(negedge clk);
      end
      ready_in[0] = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_ready", 32'(rdy_out[0]), 32'd1);
      chk("t6_rst_valid", 32'(dout_valid[0]), 32'd0);
      chk("t6_rst_dout", 32'(dout[0]), 32'd0);
      chk("t6_rst_chan", 32'(dout_chan[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_word(0, 24'h000042, -1, 0, 1'b0);
      recv_word(0, 24'h000042, 1'b0, 0, -1, 0, "t6_after_rst", lat);
      chk("t6_latency", 32'(lat), 32'(NT + 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
